// File: rtl/rec_pwm_generator.sv
// Center-aligned complementary PWM with dead-band insertion and double-buffered duty.
// Optional carrier-zero sync pulse output when REC_PWM_SYNC_OUT_EN is defined.
module rec_pwm_generator #(
   parameter logic [15:0] PWM_PERIOD = 16'd5000,
   parameter logic [15:0] DEAD_TIME  = 16'd200
) (
   input  logic        clk_100,
   input  logic        RSTn,
   input  logic        PwmEn,
   input  logic [15:0] Duty,
   input  logic        DutyLd,
   output logic        Pwm1,
   output logic        Pwm2
`ifdef REC_PWM_SYNC_OUT_EN
   ,
   output logic        SyncOut
`endif
);

   typedef enum logic [1:0] {StOff, StDead, StPOn, StNOn} state_e;

   state_e      state_q, state_d;
   logic [15:0] carrier_q, carrier_d;
   logic        dir_up_q, dir_up_d;
   logic [15:0] pend_q, pend_d;
   logic [15:0] active_q, active_d;
   logic [15:0] dead_cnt_q, dead_cnt_d;
   logic        pwm1_q, pwm1_d;
   logic        pwm2_q, pwm2_d;
   logic        carrier_zero;
   logic        raw;

   assign carrier_zero = (carrier_q == 16'd0);
   assign raw          = (carrier_q < active_q);

   // Triangle carrier: 0 .. PWM_PERIOD .. 0, period 2*PWM_PERIOD
   always_comb begin
      carrier_d = carrier_q;
      dir_up_d  = dir_up_q;
      if (!PwmEn) begin
         carrier_d = 16'd0;
         dir_up_d  = 1'b1;
      end else if (dir_up_q) begin
         if (carrier_q >= PWM_PERIOD) begin
            carrier_d = PWM_PERIOD - 16'd1;
            dir_up_d  = 1'b0;
         end else begin
            carrier_d = carrier_q + 16'd1;
         end
      end else begin
         if (carrier_zero) begin
            carrier_d = 16'd1;
            dir_up_d  = 1'b1;
         end else begin
            carrier_d = carrier_q - 16'd1;
         end
      end
   end

   // Pending holds across disable; active reloads only at carrier zero, so a
   // coincident DutyLd lands one period later.
   always_comb begin
      pend_d = pend_q;
      if (DutyLd) begin
         pend_d = (Duty > PWM_PERIOD) ? PWM_PERIOD : Duty;
      end
      active_d = active_q;
      if (!PwmEn) begin
         active_d = 16'd0;
      end else if (carrier_zero) begin
         active_d = pend_q;
      end
   end

   always_ff @(posedge clk_100 or negedge RSTn) begin
      if (!RSTn) begin
         carrier_q <= 16'd0;
         dir_up_q  <= 1'b1;
         pend_q    <= 16'd0;
         active_q  <= 16'd0;
      end else begin
         carrier_q <= carrier_d;
         dir_up_q  <= dir_up_d;
         pend_q    <= pend_d;
         active_q  <= active_d;
      end
   end

   always_ff @(posedge clk_100 or negedge RSTn) begin
      if (!RSTn) begin
         state_q    <= StOff;
         dead_cnt_q <= 16'd0;
      end else begin
         state_q    <= state_d;
         dead_cnt_q <= dead_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      dead_cnt_d = dead_cnt_q;
      if (!PwmEn) begin
         state_d    = StOff;
         dead_cnt_d = 16'd0;
      end else begin
         unique case (state_q)
            StOff: begin
               state_d    = StDead;
               dead_cnt_d = 16'd0;
            end
            StDead: begin
               dead_cnt_d = dead_cnt_q + 16'd1;
               // Leg choice uses raw in the exit cycle only
               if (dead_cnt_q == DEAD_TIME - 16'd1) begin
                  state_d = raw ? StPOn : StNOn;
               end
            end
            StPOn: begin
               if (!raw) begin
                  state_d    = StDead;
                  dead_cnt_d = 16'd0;
               end
            end
            StNOn: begin
               if (raw) begin
                  state_d    = StDead;
                  dead_cnt_d = 16'd0;
               end
            end
            default: begin
               state_d    = StOff;
               dead_cnt_d = 16'd0;
            end
         endcase
      end
   end

   // PwmEn gates the decode so a disable kills both legs on the very next edge
   always_comb begin
      pwm1_d = PwmEn && (state_q == StPOn);
      pwm2_d = PwmEn && (state_q == StNOn);
   end

   always_ff @(posedge clk_100 or negedge RSTn) begin
      if (!RSTn) begin
         pwm1_q <= 1'b0;
         pwm2_q <= 1'b0;
      end else begin
         pwm1_q <= pwm1_d;
         pwm2_q <= pwm2_d;
      end
   end

   assign Pwm1 = pwm1_q;
   assign Pwm2 = pwm2_q;

`ifdef REC_PWM_SYNC_OUT_EN
   logic sync_q;

   always_ff @(posedge clk_100 or negedge RSTn) begin
      if (!RSTn) begin
         sync_q <= 1'b0;
      end else begin
         sync_q <= PwmEn && carrier_zero;
      end
   end

   assign SyncOut = sync_q;
`endif

endmodule

// File: tb/tb_rec_pwm_generator.sv
// Randomized bench for rec_pwm_generator against a triangle-wave / dead-band reference model.
// Build with REC_PWM_SYNC_OUT_EN defined to also check SyncOut.
module tb_rec_pwm_generator;

   localparam int P  = 60;
   localparam int DT = 7;
   localparam int NCYC = 20000;

   // Reference leg modes
   localparam int LegOff  = 0;
   localparam int LegDead = 1;
   localparam int LegPos  = 2;
   localparam int LegNeg  = 3;

   logic        clk_100 = 1'b0;
   logic        RSTn;
   logic        PwmEn;
   logic [15:0] Duty;
   logic        DutyLd;
   logic        Pwm1;
   logic        Pwm2;
`ifdef REC_PWM_SYNC_OUT_EN
   logic        SyncOut;
`endif

   rec_pwm_generator #(
      .PWM_PERIOD (16'(P)),
      .DEAD_TIME  (16'(DT))
   ) dut (
      .clk_100 (clk_100),
      .RSTn    (RSTn),
      .PwmEn   (PwmEn),
      .Duty    (Duty),
      .DutyLd  (DutyLd),
      .Pwm1    (Pwm1),
`ifdef REC_PWM_SYNC_OUT_EN
      .Pwm2    (Pwm2),
      .SyncOut (SyncOut)
`else
      .Pwm2    (Pwm2)
`endif
   );

   always #5 clk_100 = ~clk_100;

   int n_vec = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference state: time since enable, pending/active duty, leg mode
   int t, pending, active, mode, elapsed;
   bit e_p1, e_p2, e_sync;

   function automatic int carrier_at(input int tt);
      int m;
      m = tt % (2 * P);
      return (m <= P) ? m : 2 * P - m;
   endfunction

   task automatic model_reset();
      t = 0; pending = 0; active = 0; mode = LegOff; elapsed = 0;
      e_p1 = 0; e_p2 = 0; e_sync = 0;
   endtask

   task automatic model_step(input bit en, input bit ld, input int duty);
      int  c;
      bit  raw;
      c      = carrier_at(t);
      raw    = c < active;
      e_sync = en && (c == 0);
      e_p1   = en && (mode == LegPos);
      e_p2   = en && (mode == LegNeg);
      if (!en) begin
         t = 0; active = 0; mode = LegOff; elapsed = 0;
      end else begin
         if (c == 0) active = pending;
         t = (t + 1) % (2 * P);
         case (mode)
            LegOff: begin mode = LegDead; elapsed = 0; end
            LegDead: begin
               elapsed++;
               if (elapsed >= DT) mode = raw ? LegPos : LegNeg;
            end
            LegPos: if (!raw) begin mode = LegDead; elapsed = 0; end
            default: if (raw) begin mode = LegDead; elapsed = 0; end
         endcase
      end
      if (ld) pending = (duty > P) ? P : duty;
   endtask

   int  cyc = 0;
   int  last1 = -1, last2 = -1;
   bit  prev1 = 0, prev2 = 0;
   int  off_left = 0;
   int  n_inj = 0;
   int  next_inj = 3000;

   task automatic compare_outputs();
      check_eq("pwm1", Pwm1, e_p1);
      check_eq("pwm2", Pwm2, e_p2);
      check_eq("overlap", Pwm1 & Pwm2, 0);
`ifdef REC_PWM_SYNC_OUT_EN
      check_eq("sync", SyncOut, e_sync);
`endif
      if (Pwm1 && !prev1 && last2 >= 0) check_eq("gap_p1", (cyc - last2 - 1) >= DT, 1);
      if (Pwm2 && !prev2 && last1 >= 0) check_eq("gap_p2", (cyc - last1 - 1) >= DT, 1);
      if (Pwm1) last1 = cyc;
      if (Pwm2) last2 = cyc;
      prev1 = Pwm1;
      prev2 = Pwm2;
   endtask

   initial begin
      bit en, ld;
      int d, r;
      RSTn = 1'b0; PwmEn = 1'b0; DutyLd = 1'b0; Duty = 16'd0;
      model_reset();
      repeat (3) @(negedge clk_100);
      check_eq("reset_pwm1", Pwm1, 0);
      check_eq("reset_pwm2", Pwm2, 0);
      RSTn = 1'b1;
      for (int i = 0; i < NCYC; i++) begin
         @(negedge clk_100);
         cyc++;
         compare_outputs();
         // Asynchronous reset dropped in the middle of a dead band
         if (n_inj < 3 && cyc >= next_inj && mode == LegDead && elapsed > 1) begin
            #2 RSTn = 1'b0;
            #1;
            check_eq("async_rst_pwm1", Pwm1, 0);
            check_eq("async_rst_pwm2", Pwm2, 0);
`ifdef REC_PWM_SYNC_OUT_EN
            check_eq("async_rst_sync", SyncOut, 0);
`endif
            model_reset();
            last1 = -1; last2 = -1; prev1 = 0; prev2 = 0;
            @(negedge clk_100);
            RSTn = 1'b1;
            n_inj++;
            next_inj = cyc + 5000;
         end
         if (off_left > 0) begin
            en = 0;
            off_left--;
         end else begin
            en = 1;
            if ($urandom_range(299) == 0) off_left = $urandom_range(20, 1);
         end
         ld = ($urandom_range(39) == 0);
         r  = $urandom_range(9);
         if (r == 0)      d = 0;
         else if (r == 1) d = P + $urandom_range(30);
         else if (r == 2) d = $urandom_range(DT);
         else             d = $urandom_range(P);
         PwmEn  = en;
         DutyLd = ld;
         Duty   = 16'(d);
         model_step(en, ld, d);
      end
      @(negedge clk_100);
      cyc++;
      compare_outputs();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rec_pwm_generator.md
REC_PWM_GENERATOR -- requirements
Module: rec_pwm_generator

Interface
REQ-001 The block SHALL have parameter PWM_PERIOD, default 16'd5000, which sets the carrier peak count; the carrier period is 2*PWM_PERIOD clk_100 cycles.
REQ-002 The block SHALL have parameter DEAD_TIME, default 16'd200, which sets the number of clk_100 cycles both outputs stay low between complementary transitions.
REQ-003 clk_100  input  1  system clock, 100 MHz; single clock domain.
REQ-004 RSTn  input  1  reset; asynchronous, active-low.
REQ-005 PwmEn  input  1  synchronous run enable; high = generate.
REQ-006 Duty  input  16  requested compare value, unsigned.
REQ-007 DutyLd  input  1  single-cycle strobe; writes Duty into the pending register.
REQ-008 Pwm1  output  1  positive-leg gate command, registered.
REQ-009 Pwm2  output  1  negative-leg gate command, registered.
REQ-010 SyncOut  output  1  carrier-zero pulse; present only when REC_PWM_SYNC_OUT_EN is defined.

Function
REQ-011 The carrier SHALL be a 16-bit up/down counter: counting up, at PWM_PERIOD it reverses and next takes PWM_PERIOD-1; counting down, at 0 it reverses and next takes 1.
REQ-012 On DutyLd=1, the pending register SHALL take min(Duty, PWM_PERIOD); the pending register SHALL hold otherwise, including while PwmEn=0.
REQ-013 The active duty SHALL take the pending value only in a cycle where PwmEn=1 and carrier==0 (one load per carrier period, no mid-period change).
REQ-014 If DutyLd coincides with the carrier==0 update, the active duty SHALL take the old pending value and the new value SHALL apply at the next zero.
REQ-015 Raw compare: raw=1 when carrier < active duty; raw=0 otherwise. Duty 0 gives raw constantly 0.
REQ-016 Output FSM states:
 - OFF: both outputs 0.
 - DEAD: both outputs 0; dead counter runs.
 - P_ON: Pwm1=1.
 - N_ON: Pwm2=1.
REQ-017 From OFF with PwmEn=1, the FSM SHALL enter DEAD with the dead counter cleared.
REQ-018 From P_ON when raw=0, or from N_ON when raw=1, the FSM SHALL enter DEAD with the dead counter cleared.
REQ-019 In DEAD, the counter SHALL increment each cycle. When it equals DEAD_TIME-1, the FSM SHALL go to P_ON if raw=1 and to N_ON if raw=0.
REQ-020 A raw toggle inside DEAD SHALL NOT restart the dead counter; the exit decision SHALL use raw in the exit cycle.
REQ-021 Pwm1 and Pwm2 SHALL never both be 1 in any cycle.
REQ-022 Each leg's low time between opposite-leg highs SHALL be at least DEAD_TIME cycles.
REQ-023 Output latency: Pwm1/Pwm2 SHALL change in the cycle after the FSM state change, as registered decode of the state.
REQ-024 PwmEn=0 SHALL, on the next clock edge, force:
 - Pwm1=0 and Pwm2=0;
 - carrier=0 with direction up;
 - FSM=OFF;
 - dead counter=0;
 - active duty=0.
 Pending duty SHALL be retained.
REQ-025 Pulses narrower than DEAD_TIME SHALL be absorbed: the leg stays low and nothing is lengthened.

Reset
REQ-026 RSTn low SHALL asynchronously clear the following to 0, with the FSM in OFF and the carrier direction up:
 - Pwm1, Pwm2, SyncOut;
 - carrier, dead counter;
 - pending duty, active duty.
REQ-027 Reset release mid-period SHALL restart operation as in REQ-017, with the first compare using active duty 0 until the first carrier==0 load.

Configuration
REQ-028 With REC_PWM_SYNC_OUT_EN defined, SyncOut SHALL be a registered 1-cycle pulse one cycle after each carrier==0 with PwmEn=1.
REQ-029 Without REC_PWM_SYNC_OUT_EN, the SyncOut port and its logic SHALL be absent.

Verification
REQ-030 Run 4 carrier periods with defaults, Duty=2500 loaded once:
 - carrier reverses at 5000 and at 0; period = 10000 cycles;
 - Pwm1 high about 4800 cycles per period.
REQ-031 Duty=2500, check every cycle for one period:
 - Pwm1&Pwm2 never 1;
 - each gap between opposite-leg highs is exactly 200 cycles.
REQ-032 Duty changes 1000 -> 4000 with DutyLd mid-period: output is unchanged until the next carrier==0, then the new width applies.
REQ-033 Duty=6000 gives active duty 5000, with Pwm1 low only during dead bands. Duty=0 gives Pwm2 high after the initial 200-cycle dead band, with Pwm1 always 0.
REQ-034 PwmEn drops while Pwm1=1:
 - next edge: both outputs 0, carrier 0;
 - after PwmEn returns: 200 cycles low before any leg rises.
REQ-035 RSTn asserted asynchronously mid-DEAD: outputs 0 immediately. With REC_PWM_SYNC_OUT_EN defined, SyncOut pulses once per 10000 cycles.
